// File: rtl/io_trap_decoder.sv
// io_trap_decoder: traps Z80 I/O cycles matching programmable base/mask slots
module io_trap_decoder #(
  parameter int NSLOT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       virtual_enabled,
  input  logic       cfg_wr,
  input  logic [3:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       trap_ack,
  output logic       trap_condition,
  output logic [7:0] trap_port,
  output logic [7:0] trap_data,
  output logic       trap_dir,
  output logic [1:0] trap_slot,
  output logic       trap_overrun
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t     state;
  logic       iorq_q;
  logic [7:0] base [NSLOT];
  logic [7:0] mask [NSLOT];
  logic [7:0] en;
  logic [NSLOT-1:0] match;
  logic       is_wr, is_rd, start, hit;
  logic [1:0] hit_slot;
  assign is_wr = !wr_n;
  assign is_rd = wr_n && !rd_n;
  for (genvar n = 0; n < NSLOT; n++) begin : g_slot
    assign match[n] = (((addr ^ base[n]) & mask[n]) == 8'h00) && (is_wr ? en[NSLOT+n] : is_rd && en[n]);
  end
  // lowest-numbered matching slot wins; first edge of a non-interrupt I/O cycle evaluates
  always_comb begin
    hit_slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) if (match[i]) hit_slot = 2'(i);
    start = (state == IDLE) && !iorq_n && iorq_q && m1_n;
    hit = start && virtual_enabled && |match;
  end
  // write-only config registers, old values still used by a same-edge evaluation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        base[i] <= '0;
        mask[i] <= '0;
      end
      en <= '0;
    end else if (cfg_wr) begin
      if (cfg_addr < 4'd4) base[cfg_addr[1:0]] <= cfg_data;
      else if (cfg_addr < 4'd8) mask[cfg_addr[1:0]] <= cfg_data;
      else if (cfg_addr == 4'd8) en <= cfg_data;
    end
  end
  // cycle FSM plus trap latch; a new hit beats a coincident ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      iorq_q <= 1'b1;
      trap_condition <= 1'b0;
      trap_port <= '0;
      trap_data <= '0;
      trap_dir <= 1'b0;
      trap_slot <= '0;
      trap_overrun <= 1'b0;
    end else begin
      iorq_q <= iorq_n;
      state <= start ? ACTIVE : (state == ACTIVE && iorq_n) ? IDLE : state;
      if (hit && (!trap_condition || trap_ack)) begin
        trap_condition <= 1'b1;
        trap_port <= addr;
        trap_data <= is_wr ? data : 8'h00;
        trap_dir <= is_wr;
        trap_slot <= hit_slot;
        trap_overrun <= 1'b0;
      end else if (hit) trap_overrun <= 1'b1;
      else if (trap_ack) begin
        trap_condition <= 1'b0;
        trap_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: doc/io_trap_decoder.md
# io_trap_decoder

Upstream feeder for the trap/NMI mode logic in the Nabu CPLD. Watches Z80 I/O bus cycles and compares each port address against four programmable base/mask match slots. On a hit while virtualization is enabled, it latches port, data, direction and slot, then raises `trap_condition` to the mode logic. The condition is held until the hypervisor side acknowledges it.

## Interface
- `NSLOT`, 4: number of match slots. Fixed at 4; the config map depends on it.
- `clk`  in  1  Z80 CPU clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `iorq_n`  in  1  Z80 IORQ.
- `m1_n`  in  1  Z80 M1. IORQ with M1 low is interrupt acknowledge and is never trapped.
- `rd_n`  in  1  Z80 RD.
- `wr_n`  in  1  Z80 WR.
- `addr`  in  8  Z80 A[7:0] (port number).
- `data`  in  8  Z80 D[7:0].
- `virtual_enabled`  in  1  trap matching allowed when high.
- `cfg_wr`  in  1  one-clk config write strobe.
- `cfg_addr`  in  4  config register select.
- `cfg_data`  in  8  config write data.
- `trap_ack`  in  1  one-clk pulse that clears a pending trap.
- `trap_condition`  out  1  trap pending, level.
- `trap_port`  out  8  latched port of trapped cycle.
- `trap_data`  out  8  latched write data; 0x00 for reads.
- `trap_dir`  out  1  1 = OUT (write), 0 = IN (read).
- `trap_slot`  out  2  index of the matching slot.
- `trap_overrun`  out  1  sticky: a match arrived while a trap was already pending.

## Operation
- **Config map** (written on `cfg_wr`):
  - 0–3: `base[n]`.
  - 4–7: `mask[n]`.
  - 8: enables. Bits [3:0] are read-enable for slots 0–3; bits [7:4] are write-enable for slots 0–3.
  - 9–15: ignored.
  - Config is write-only; no readback.
- **Slot match** for slot n: `((addr ^ base[n]) & mask[n]) == 0`, and the slot's direction enable is set. A mask bit of 1 means that bit is compared; mask 0x00 matches every port.
- **Priority**: the lowest-numbered matching slot wins.
- **Cycle detection FSM**, states IDLE, ACTIVE:
  - IDLE → ACTIVE on an edge where `iorq_n`=0, the registered `iorq_q`=1, and `m1_n`=1.
  - Evaluation happens on that transition edge:
    - Direction: `wr_n`=0 gives write; otherwise `rd_n`=0 gives read.
    - If both strobes are high, or `virtual_enabled`=0, there is no match evaluation.
  - ACTIVE → IDLE when `iorq_n`=1. Exactly one evaluation is made per I/O cycle, regardless of wait states.
- **On a hit**:
  - Latch `trap_port`=`addr`, `trap_slot`, and `trap_dir`.
  - Set `trap_data`=`data` for a write, or 0x00 for a read.
  - Set `trap_condition`=1.
- **Hit while `trap_condition`=1**: latched fields are not overwritten; `trap_overrun` is set.
- **`trap_ack`**: clears `trap_condition` and `trap_overrun`. Latched fields keep their values.
- **Ack and new hit on the same edge**: the new hit wins. Fields are latched, `trap_condition` stays 1, and `trap_overrun` is cleared.
- **Config write on the same edge as evaluation**: evaluation uses the old register values.
- **Dropping `virtual_enabled`**: does not clear a pending trap.

## Timing
- **Reset values**:
  - All outputs 0: `trap_condition`, `trap_port`, `trap_data`, `trap_dir`, `trap_slot`, `trap_overrun`.
  - All base, mask and enable registers 0, so nothing traps.
  - FSM in IDLE; `iorq_q`=1.
- **Latency**: `trap_condition` and the latched fields are valid on the first rising edge after the edge where IORQ is first seen low. Effectively they are registered at the detection edge and visible by T3/Tw.
- **Mid-cycle reset**: reset asserted during an I/O cycle returns to IDLE. If `iorq_n` is still low after reset releases, `iorq_q` initialises to 1, so that cycle may be evaluated once; this is acceptable.
- **Config latency**: a config write takes effect on the following edge.
- **Signal types**: `trap_condition` is a level, not a pulse. `trap_ack` must be a single clock.

## Test plan
- **Basic write trap**: base0=0x40, mask0=0xF0, enables=0x10, `virtual_enabled`=1, OUT (0x45),0xA5 → `trap_condition`=1, port 0x45, data 0xA5, dir 1, slot 0. OUT to 0x55 → no trap.
- **Priority and direction**: slot1 base 0x80/mask 0xFF read-en; slot2 base 0x80/mask 0x80 read-en; IN from 0x80 → slot 1, dir 0, data 0x00. The same port with only write-enable set → no trap.
- **Interrupt acknowledge and gating**: IORQ with M1 low at a port matching slot 0 → no trap. Match with `virtual_enabled`=0 → no trap.
- **Overrun and acknowledge**: first trap (port 0x41) pending, second match (port 0x42) → fields still show 0x41, `trap_overrun`=1. `trap_ack` → both flags 0. `trap_ack` coincident with a new hit at 0x43 → `trap_condition`=1, port 0x43, overrun 0.
- **Wait states and reset**: I/O cycle stretched by 5 wait states → exactly one evaluation. Assert `reset_n` low with a trap pending → all outputs 0 immediately, with no clock needed. After reset, the same access does not trap because config was cleared.
